// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//   Shares one FIFO write port between NUM_REQ producers. Grants rotate
//   round-robin and each grant is limited to BURST_LEN accepted words, so no
//   producer can starve the others. The FIFO write side is driven
//   combinationally from the granted producer with zero added latency.
//
//   Build option: FIFO_WRITE_ARB_PRIO_EN
//     defined   - requester 0 wins every pick point it is valid at, and its
//                 bursts do not move last_grant, so requesters 1..N-1 keep
//                 their rotation.
//     undefined - pure round-robin.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   req_valid     per-requester word valid
//   req_data      requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     per-requester accept (one-hot or zero)
//   fifo_wr_data  FIFO write data (don't-care while fifo_wr_en is low)
//   fifo_wr_en    FIFO write enable
//   fifo_full     FIFO full flag
//   grant         registered one-hot current owner, zero when idle
//   busy          high while a burst is granted
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no owner; the first valid request is picked on the next edge
// S_BURST | grant owns the FIFO port until BURST_LEN words or valid drops
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic                          fifo_wr_en,
   input  logic                          fifo_full,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy
);

   localparam int CNT_W = $clog2(BURST_LEN + 1);
   localparam int LG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   logic [0:0]            r_state;
   logic [NUM_REQ-1:0]    r_grant;
   logic [LG_W-1:0]       r_last;
   logic [CNT_W-1:0]      r_count;

   logic [0:0]            w_state_nxt;
   logic [NUM_REQ-1:0]    w_grant_nxt;
   logic [LG_W-1:0]       w_last_nxt;
   logic [CNT_W-1:0]      w_count_nxt;

   logic [NUM_REQ-1:0]    w_ready;
   logic                  w_xfer;
   logic                  w_owner_valid;
   logic                  w_burst_end;
   logic [LG_W-1:0]       w_gidx;
   logic [LG_W-1:0]       w_new_last;
   logic [NUM_REQ-1:0]    w_pick_idle;
   logic [NUM_REQ-1:0]    w_pick_end;
   logic [DATA_WIDTH-1:0] w_wr_data;

   // First valid requester strictly after base, wrapping; base itself is
   // checked last so the previous owner has lowest priority.
   function automatic logic [NUM_REQ-1:0] f_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [LG_W-1:0]    base);
      logic [NUM_REQ-1:0] sel;
      logic               found;
      int                 idx;
      sel   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(base) + k) % NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && (j == idx) && v[j]) begin
               sel[j] = 1'b1;
               found  = 1'b1;
            end
         end
      end
      return sel;
   endfunction

   assign busy          = (r_state == S_BURST);
   assign grant         = r_grant;
   assign w_ready       = busy ? (r_grant & {NUM_REQ{~fifo_full}}) : '0;
   assign req_ready     = w_ready;
   assign w_xfer        = |(req_valid & w_ready);
   assign fifo_wr_en    = w_xfer;
   assign w_owner_valid = |(req_valid & r_grant);

   // A full FIFO blocks the transfer but the owner keeps valid high, so the
   // burst is simply held rather than ended.
   assign w_burst_end = !w_owner_valid ||
                        (w_xfer && (r_count == CNT_W'(BURST_LEN - 1)));

   always_comb begin
      w_gidx    = '0;
      w_wr_data = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (r_grant[j]) begin
            w_gidx    = w_gidx | LG_W'(j);
            w_wr_data = w_wr_data | req_data[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign fifo_wr_data = w_wr_data;

`ifdef FIFO_WRITE_ARB_PRIO_EN
   // Requester 0 bursts leave the rotation pointer where it was.
   assign w_new_last  = r_grant[0] ? r_last : w_gidx;
   assign w_pick_idle = req_valid[0] ? NUM_REQ'(1) : f_pick(req_valid, r_last);
   assign w_pick_end  = req_valid[0] ? NUM_REQ'(1) : f_pick(req_valid, w_new_last);
`else
   assign w_new_last  = w_gidx;
   assign w_pick_idle = f_pick(req_valid, r_last);
   assign w_pick_end  = f_pick(req_valid, w_new_last);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      w_count_nxt = r_count;
      case (r_state)
         S_IDLE: begin
            if (|req_valid) begin
               w_grant_nxt = w_pick_idle;
               w_count_nxt = '0;
               w_state_nxt = S_BURST;
            end
         end
         S_BURST: begin
            if (w_burst_end) begin
               // Handover uses this cycle's valids, so there is no bubble.
               w_last_nxt  = w_new_last;
               w_count_nxt = '0;
               if (|req_valid) begin
                  w_grant_nxt = w_pick_end;
               end else begin
                  w_grant_nxt = '0;
                  w_state_nxt = S_IDLE;
               end
            end else if (w_xfer) begin
               w_count_nxt = r_count + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_count_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_last  <= LG_W'(NUM_REQ - 1);
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
         r_count <= w_count_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//   Directed bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=8,
//   BURST_LEN=4). A vector table covers single-cycle behaviour; streaming
//   sequences cover burst rotation, back-to-back handover and reset mid-burst.
//   Requester i word n carries data {i, n} as two nibbles.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  fifo_wr_data;
   logic        fifo_wr_en;
   logic        fifo_full;
   logic [3:0]  grant;
   logic        busy;

   int n_checks;
   int n_errors;

   int          n_w [4];
   int          cnt [4];
   logic [7:0]  exp_q [$];

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic        full;
      logic [3:0]  g;
      logic        bsy;
      logic [3:0]  rdy;
      logic        wen;
      logic [7:0]  wd;
   } vec_t;

   vec_t tbl [15];

   fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_wr_data (fifo_wr_data),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_full    (fifo_full),
      .grant        (grant),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_w[i] = 0;
         cnt[i] = 0;
      end
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic drive_producers();
      for (int i = 0; i < 4; i++) begin
         req_valid[i]       = (n_w[i] < cnt[i]);
         req_data[i*8 +: 8] = {4'(i), 4'(n_w[i])};
      end
   endtask

   // Producers hold words until accepted; every write is matched against
   // exp_q in order.
   task automatic run_stream(input string nm, input int n_exp, input bit contig,
                             input int exp_first);
      int k;
      int first;
      int last;
      int cyc;
      k     = 0;
      first = -1;
      last  = -1;
      cyc   = 0;
      while (k < n_exp && cyc < 300) begin
         @(negedge clk);
         drive_producers();
         #1;
         chk({nm, " ready_onehot"}, 32'($countones(req_ready) <= 1), 32'd1);
         if (fifo_wr_en) begin
            chk({nm, " wr_data"}, 32'(fifo_wr_data), 32'(exp_q[k]));
            if (first < 0) first = cyc;
            last = cyc;
            k++;
            for (int i = 0; i < 4; i++)
               if (req_ready[i] && req_valid[i]) n_w[i]++;
         end
         cyc++;
      end
      chk({nm, " word_count"}, 32'(k), 32'(n_exp));
      if (exp_first >= 0)
         chk({nm, " first_write_cycle"}, 32'(first), 32'(exp_first));
      if (contig)
         chk({nm, " no_gap"}, 32'(last - first), 32'(n_exp - 1));
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;

      //           valid    data           full  grant    busy  ready    wen   wdata
      tbl[0]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      tbl[0]  = '{4'b0100, 32'h00200000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      tbl[1]  = '{4'b0100, 32'h00200000, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h20};
      tbl[2]  = '{4'b0100, 32'h00210000, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h21};
      tbl[3]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00};
      tbl[4]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      tbl[5]  = '{4'b0110, 32'h00221000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      tbl[6]  = '{4'b0110, 32'h00221000, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h10};
      tbl[7]  = '{4'b0110, 32'h00221100, 1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 8'h00};
      tbl[8]  = '{4'b0110, 32'h00221100, 1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 8'h00};
      tbl[9]  = '{4'b0110, 32'h00221100, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h11};
      tbl[10] = '{4'b0110, 32'h00221200, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h12};
      tbl[11] = '{4'b0110, 32'h00221300, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h13};
      tbl[12] = '{4'b0100, 32'h00220000, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h22};
      tbl[13] = '{4'b0000, 32'h00000000, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00};
      tbl[14] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};

      // Reset state
      do_reset();
      #1;
      chk("reset grant", 32'(grant), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset ready", 32'(req_ready), 32'h0);
      chk("reset wr_en", 32'(fifo_wr_en), 32'h0);

      // Table: R2 drops after 2 words, R1 wins next, R1 stalled by full
      for (int v = 0; v < 15; v++) begin
         @(negedge clk);
         req_valid = tbl[v].valid;
         req_data  = tbl[v].data;
         fifo_full = tbl[v].full;
         #1;
         chk($sformatf("tbl%0d grant", v), 32'(grant), 32'(tbl[v].g));
         chk($sformatf("tbl%0d busy", v), 32'(busy), 32'(tbl[v].bsy));
         chk($sformatf("tbl%0d ready", v), 32'(req_ready), 32'(tbl[v].rdy));
         chk($sformatf("tbl%0d wr_en", v), 32'(fifo_wr_en), 32'(tbl[v].wen));
         if (tbl[v].wen)
            chk($sformatf("tbl%0d wr_data", v), 32'(fifo_wr_data), 32'(tbl[v].wd));
      end

      // R0 alone streams 6 words with a seamless re-grant after 4
      do_reset();
      cnt[0] = 6;
      for (int n = 0; n < 6; n++) exp_q.push_back({4'h0, 4'(n)});
      run_stream("r0_stream", 6, 1'b1, 1);

      // All four requesters, 8 words each: 4xR0,4xR1,4xR2,4xR3,4xR0,...
      do_reset();
      for (int i = 0; i < 4; i++) cnt[i] = 8;
      for (int rnd = 0; rnd < 2; rnd++)
         for (int r = 0; r < 4; r++)
            for (int w = 0; w < 4; w++)
               exp_q.push_back({4'(r), 4'(rnd*4 + w)});
      run_stream("all_four", 32, 1'b1, 1);

      // Reset asserted mid-burst after 2 of 4 words
      do_reset();
      cnt[0] = 4;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h01);
      run_stream("pre_reset", 2, 1'b1, 1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset grant", 32'(grant), 32'h0);
      chk("async_reset busy", 32'(busy), 32'h0);
      chk("async_reset wr_en", 32'(fifo_wr_en), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      cnt[1] = 1;
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h10);
      run_stream("post_reset", 3, 1'b0, -1);

      // R0 and R3 both requesting
      do_reset();
      cnt[0] = 8;
      cnt[3] = 2;
`ifdef FIFO_WRITE_ARB_PRIO_EN
      for (int n = 0; n < 8; n++) exp_q.push_back({4'h0, 4'(n)});
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h31);
      run_stream("prio_r0", 10, 1'b0, 1);
`else
      for (int n = 0; n < 4; n++) exp_q.push_back({4'h0, 4'(n)});
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h31);
      for (int n = 4; n < 8; n++) exp_q.push_back({4'h0, 4'(n)});
      run_stream("rr_r0_r3", 10, 1'b0, 1);
`endif

      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
